rom_rr_arbiter: RTL and testbench
=================================

Name: rom_rr_arbiter

Overview:
- Shares one combinational 8-bit ROM (addr/read/ena/data interface) between NUM_REQ requesters.
- Each requester issues a single-address read over a valid/ready request channel.
- The arbiter grants requesters round-robin, drives the ROM for one cycle, registers the byte, and returns it on one shared valid/ready response channel tagged with the requester id.
- Sits between fetch-side clients and the program ROM.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 13, ROM address width.
- DATA_W, 8, ROM data width.
- DEPTH, 256, populated ROM entries; any address >= DEPTH is out of range.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept; one-hot or zero.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  DATA_W  returned byte.
- rsp_id  out  2  index of the requester that owns the response.
- rsp_err  out  1  set when the address was out of range.
- rom_addr  out  ADDR_W  ROM address.
- rom_read  out  1  ROM read strobe.
- rom_ena  out  1  ROM enable.
- rom_data  in  DATA_W  ROM data; may be Z while not enabled.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - rom_addr=0, rom_read=0, rom_ena=0, req_ready=0.
  - A reset mid-transaction aborts it; the pending response is dropped and never presented.
- FSM: IDLE -> READ -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant g = the first valid index searching from rr_ptr upward with wrap.
  - req_ready[g]=1 combinationally this cycle; the handshake completes here.
  - Register addr_q=req_addr[g] and id_q=g; go to READ.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- READ (exactly 1 cycle):
  - rom_addr=addr_q.
  - If addr_q<DEPTH: rom_read=rom_ena=1; at the clock edge rsp_data<=rom_data and rsp_err<=0.
  - If addr_q>=DEPTH: rom_read=rom_ena=0, rsp_data<=0, rsp_err<=1.
  - At the edge: rsp_id<=id_q, rr_ptr<=(id_q+1) mod NUM_REQ.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge go to IDLE; rsp_valid falls next cycle.
  - req_ready=0 throughout RESP.
- Outside READ: rom_read=rom_ena=0 and rom_addr holds its last value. rom_data is never sampled outside READ.
- Latency: request accept at cycle N, rsp_valid high at N+2. Maximum throughput is one transaction per 3 cycles.
- Request-channel rules:
  - req_ready may depend on req_valid.
  - A requester must hold req_valid and req_addr until accepted.
  - A requester that is not granted sees req_ready low and keeps waiting.
- Fairness: a continuously valid requester is granted within NUM_REQ transactions.
- NUM_REQ values that are not a power of 2 wrap rr_ptr explicitly: NUM_REQ-1 -> 0.
- Address wrap: ADDR_W-bit values only; no arithmetic is done on the address.

Optional Feature:
- ROM_ARB_PARITY_EN defined:
  - Adds output port rsp_parity (1 bit) = XOR of rsp_data, registered with rsp_data. Even parity; 0 for out-of-range responses.
  - Reset value 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package rom_arb_pkg holds:
  - state enum {IDLE, READ, RESP};
  - constants ADDR_W_DEF=13, DATA_W_DEF=8, DEPTH_DEF=256;
  - ID_W=2.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: valid vector, rr_ptr.
  - Outputs: grant one-hot, grant index, any_valid.
- The FSM and datapath registers stay in rom_rr_arbiter.

Test Plan:
- Single request: ROM preloaded with mem[5]=8'hA5; req 0 addr=5, rsp_ready=1 -> req_ready[0] high in the valid cycle; rsp_valid two cycles later with data=A5, id=0, err=0; rom_ena/rom_read high for exactly 1 cycle with rom_addr=5.
- Contention: req 0 and req 1 both valid continuously with addrs 1 and 2, mem[1]=11, mem[2]=22 -> responses alternate id 0,1,0,1 with data 11,22,11,22; neither requester gets two grants in a row.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid stays high, data/id stable, req_ready stays 0; accepted on the first cycle rsp_ready=1.
- Out of range: addr=13'h100 -> rsp_err=1, rsp_data=0, rom_ena never asserted.
- Reset mid-op: rst=1 during READ -> next cycle rsp_valid=0, all outputs 0, rr_ptr=0; a subsequent request from req 1 alone is served normally.
- Parity (ROM_ARB_PARITY_EN): mem[7]=8'h07 -> rsp_parity=1; mem[3]=8'h03 -> rsp_parity=0.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM round-robin arbiter.
//   state_t    : transaction FSM states (IDLE -> READ -> RESP)
//   *_DEF      : default address/data widths and populated ROM depth
//   ID_W       : width of the requester index carried on the response
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;
    localparam int ID_W       = 2;

endpackage

// File: rtl/rom_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   valid     : per-requester valid vector
//   rr_ptr    : index with highest priority this round
//   grant     : one-hot grant (zero when nothing is valid)
//   grant_idx : index of the granted requester
//   any_valid : at least one requester is valid
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_valid
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Walk upward from rr_ptr; one subtraction wraps any NUM_REQ.
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
        any_valid = found;
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: shares one combinational ROM between NUM_REQ requesters.
// Requests are granted round-robin, the ROM is driven for exactly one cycle,
// and the registered byte is returned on a shared response channel tagged
// with the requester id.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester request handshake
//   req_addr            : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   rsp_valid/rsp_ready : response handshake
//   rsp_data/id/err     : returned byte, owning requester, out-of-range flag
//   rom_addr/read/ena   : ROM control, active only in the READ cycle
//   rom_data            : ROM output (may float while not enabled)
// Optional: define ROM_ARB_PARITY_EN to add rsp_parity (XOR of rsp_data).
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_read,
    output logic                      rom_ena,
    input  logic [DATA_W-1:0]         rom_data
`ifdef ROM_ARB_PARITY_EN
    ,
    output logic                      rsp_parity
`endif
);

    state_t              state;
    state_t              state_nx;
    logic [ID_W-1:0]     rr_ptr;
    logic [ADDR_W-1:0]   addr_q;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                any_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic                in_range;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign in_range = (32'(addr_q) < 32'(DEPTH));

    // ROM address shows addr_q only while reading; otherwise it holds the
    // address of the last read so the ROM pins do not toggle in IDLE.
    assign rom_addr = (state == READ) ? addr_q : rom_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rom_read  = 1'b0;
        rom_ena   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so no handshake appears to complete on a
                // reset edge.
                if (any_valid && !rst) begin
                    req_ready = grant;
                    state_nx  = READ;
                end
            end
            READ: begin
                rom_read = in_range;
                rom_ena  = in_range;
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            addr_q     <= '0;
            id_q       <= '0;
            rom_addr_q <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
`ifdef ROM_ARB_PARITY_EN
            rsp_parity <= 1'b0;
`endif
        end else begin
            if (state == IDLE && any_valid) begin
                addr_q <= sel_addr;
                id_q   <= grant_idx;
            end
            if (state == READ) begin
                rom_addr_q <= addr_q;
                rsp_id     <= id_q;
                rr_ptr     <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                if (in_range) begin
                    rsp_data <= rom_data;
                    rsp_err  <= 1'b0;
`ifdef ROM_ARB_PARITY_EN
                    rsp_parity <= ^rom_data;
`endif
                end else begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
`ifdef ROM_ARB_PARITY_EN
                    rsp_parity <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter: directed scenarios plus a
// randomized run scored against a transaction-level reference model.
module tb_rom_rr_arbiter;

    localparam int N     = 2;
    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_err;
    logic [AW-1:0]   rom_addr;
    logic            rom_read;
    logic            rom_ena;
    wire  [DW-1:0]   rom_data;
`ifdef ROM_ARB_PARITY_EN
    logic            rsp_parity;
`endif

    logic [7:0] mem [DEPTH];
    int errors = 0;
    int checks = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_ena ? mem[rom_addr[7:0]] : 'z;

    rom_rr_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rom_addr  (rom_addr),
        .rom_read  (rom_read),
        .rom_ena   (rom_ena),
        .rom_data  (rom_data)
`ifdef ROM_ARB_PARITY_EN
        ,
        .rsp_parity (rsp_parity)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Reference arbitration rule: first valid index at or after ptr, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_addr = '0;
        tick; tick;
        rst = 1'b0; #1;
        model_ptr = 0;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== 12'h0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b d=%h id=%0d e=%b exp all 0", rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        checks++;
        if ({rom_addr, rom_read, rom_ena, req_ready} !== 17'h0) begin
            errors++;
            $display("FAIL reset_rom: got addr=%h rd=%b ena=%b rdy=%b exp all 0", rom_addr, rom_read, rom_ena, req_ready);
        end
`ifdef ROM_ARB_PARITY_EN
        checks++;
        if (rsp_parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity: got %b exp 0", rsp_parity);
        end
`endif
    endtask

    task automatic test_single;
        mem[5] = 8'hA5;
        set_addr(0, 13'd5); req_valid = 2'b01; rsp_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 2'b01 || rom_ena !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got rdy=%b ena=%b exp rdy=01 ena=0", req_ready, rom_ena);
        end
        tick; req_valid = '0; #1;
        checks++;
        if ({rom_ena, rom_read, rom_addr, rsp_valid} !== {1'b1, 1'b1, 13'd5, 1'b0}) begin
            errors++;
            $display("FAIL single_read: got ena=%b rd=%b addr=%h v=%b exp 1 1 0005 0", rom_ena, rom_read, rom_addr, rsp_valid);
        end
        tick;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, 8'hA5, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: got v=%b d=%h id=%0d e=%b exp 1 a5 0 0", rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        checks++;
        if ({rom_ena, rom_read, rom_addr} !== {1'b0, 1'b0, 13'd5}) begin
            errors++;
            $display("FAIL single_rom_idle: got ena=%b rd=%b addr=%h exp 0 0 0005", rom_ena, rom_read, rom_addr);
        end
        tick;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: got rsp_valid=%b exp 0", rsp_valid);
        end
        model_ptr = 1;
    endtask

    task automatic test_contention;
        int exp_id;
        test_reset;
        mem[1] = 8'h11; mem[2] = 8'h22;
        set_addr(0, 13'd1); set_addr(1, 13'd2);
        req_valid = 2'b11; rsp_ready = 1'b1; #1;
        exp_id = 0;
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (req_ready !== (2'b01 << exp_id)) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b exp %b", t, req_ready, 2'b01 << exp_id);
            end
            tick; tick;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(exp_id), (exp_id == 1) ? 8'h22 : 8'h11}) begin
                errors++;
                $display("FAIL contention_rsp%0d: got v=%b id=%0d d=%h exp id=%0d", t, rsp_valid, rsp_id, rsp_data, exp_id);
            end
            tick;
            exp_id = 1 - exp_id;
        end
        req_valid = '0; #1;
        model_ptr = 0;
    endtask

    task automatic test_backpressure;
        mem[9] = 8'h5C;
        set_addr(1, 13'd9); req_valid = 2'b10; rsp_ready = 1'b0; #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_accept: got %b exp 10", req_ready);
        end
        tick;
        set_addr(0, 13'd3); req_valid = 2'b01; #1;
        tick;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, 8'h5C, 2'd1, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d rdy=%b exp 1 5c 1 00", c, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            tick;
        end
        rsp_ready = 1'b1; #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h5C) begin
            errors++;
            $display("FAIL bp_release: got v=%b d=%h exp 1 5c", rsp_valid, rsp_data);
        end
        tick;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_after: got v=%b rdy=%b exp 0 01", rsp_valid, req_ready);
        end
        req_valid = '0; #1;
        tick;
        model_ptr = 0;
    endtask

    task automatic test_out_of_range;
        logic [AW-1:0] tbl [3] = '{13'd255, 13'h100, 13'h1FFF};
        logic          inr;
        mem[255] = 8'hE7;
        for (int t = 0; t < 3; t++) begin
            inr = (tbl[t] < DEPTH);
            set_addr(0, tbl[t]); req_valid = 2'b01; rsp_ready = 1'b1; #1;
            checks++;
            if (req_ready !== 2'b01) begin
                errors++;
                $display("FAIL oor_accept%0d: got %b exp 01", t, req_ready);
            end
            tick; req_valid = '0; #1;
            checks++;
            if (rom_ena !== inr || rom_read !== inr) begin
                errors++;
                $display("FAIL oor_ena%0d: got ena=%b rd=%b exp %b", t, rom_ena, rom_read, inr);
            end
            tick;
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, inr ? 8'hE7 : 8'h00, 2'd0, ~inr}) begin
                errors++;
                $display("FAIL oor_rsp%0d: got v=%b d=%h id=%0d e=%b exp err=%b", t, rsp_valid, rsp_data, rsp_id, rsp_err, ~inr);
            end
            tick;
        end
        model_ptr = 1;
    endtask

    task automatic test_reset_midop;
        set_addr(0, 13'd5); req_valid = 2'b01; rsp_ready = 1'b1; #1;
        tick; req_valid = '0; #1;
        checks++;
        if (rom_ena !== 1'b1) begin
            errors++;
            $display("FAIL midop_read: got ena=%b exp 1", rom_ena);
        end
        rst = 1'b1; #1;
        tick; rst = 1'b0; #1;
        model_ptr = 0;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err, rom_ena, rom_read, rom_addr} !== 27'h0) begin
            errors++;
            $display("FAIL midop_clear: got v=%b d=%h id=%0d e=%b ena=%b rd=%b addr=%h exp all 0", rsp_valid, rsp_data, rsp_id, rsp_err, rom_ena, rom_read, rom_addr);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midop_dropped%0d: got rsp_valid=%b exp 0", c, rsp_valid);
            end
        end
        // Both valid right after reset: pointer must have returned to 0.
        set_addr(0, 13'd1); set_addr(1, 13'd2); req_valid = 2'b11; #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midop_ptr: got %b exp 01", req_ready);
        end
        tick; req_valid = 2'b10; #1;
        tick;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 8'h11}) begin
            errors++;
            $display("FAIL midop_rsp0: got v=%b id=%0d d=%h exp 1 0 11", rsp_valid, rsp_id, rsp_data);
        end
        tick;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL midop_req1: got %b exp 10", req_ready);
        end
        tick; req_valid = '0; #1;
        tick;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd1, 8'h22, 1'b0}) begin
            errors++;
            $display("FAIL midop_rsp1: got v=%b id=%0d d=%h e=%b exp 1 1 22 0", rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        tick;
        model_ptr = 0;
    endtask

`ifdef ROM_ARB_PARITY_EN
    task automatic test_parity;
        logic [AW-1:0] tbl [2] = '{13'd7, 13'd3};
        mem[7] = 8'h07; mem[3] = 8'h03;
        for (int t = 0; t < 2; t++) begin
            set_addr(0, tbl[t]); req_valid = 2'b01; rsp_ready = 1'b1; #1;
            tick; req_valid = '0; #1;
            tick;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_parity !== ^mem[tbl[t][7:0]]) begin
                errors++;
                $display("FAIL parity%0d: got v=%b p=%b exp 1 %b", t, rsp_valid, rsp_parity, ^mem[tbl[t][7:0]]);
            end
            tick;
        end
        model_ptr = 1;
    endtask
`endif

    task automatic test_random;
        bit            pend [N];
        logic [AW-1:0] paddr [N];
        bit            busy = 1'b0;
        bit            busy0;
        int            acc = -10;
        int            exp_id = 0;
        logic [7:0]    exp_data = '0;
        bit            exp_err = 1'b0;
        logic [AW-1:0] exp_addr = '0;
        int            g;
        logic [N-1:0]  exp_rr;
        bit            exp_v;
        bit            exp_ena;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; paddr[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (cyc < 360 && !pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    paddr[i] = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(DEPTH, 8191))
                                                           : AW'($urandom_range(0, DEPTH - 1));
                end
                req_valid[i] = pend[i];
                set_addr(i, paddr[i]);
            end
            rsp_ready = (cyc >= 360) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            busy0  = busy;
            g      = busy0 ? -1 : pick(req_valid, model_ptr);
            exp_rr = (g < 0) ? '0 : (N'(1) << g);
            checks++;
            if (req_ready !== exp_rr) begin
                errors++;
                $display("FAIL rand_ready@%0d: got %b exp %b", cyc, req_ready, exp_rr);
            end
            exp_v = busy0 && (cyc >= acc + 2);
            checks++;
            if (rsp_valid !== exp_v) begin
                errors++;
                $display("FAIL rand_valid@%0d: got %b exp %b", cyc, rsp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({rsp_data, rsp_id, rsp_err} !== {exp_data, 2'(exp_id), exp_err}) begin
                    errors++;
                    $display("FAIL rand_rsp@%0d: got d=%h id=%0d e=%b exp d=%h id=%0d e=%b", cyc, rsp_data, rsp_id, rsp_err, exp_data, exp_id, exp_err);
                end
                if (rsp_ready) busy = 1'b0;
            end
            exp_ena = busy0 && (cyc == acc + 1) && (exp_addr < DEPTH);
            checks++;
            if (rom_ena !== exp_ena || rom_read !== exp_ena || (exp_ena && rom_addr !== exp_addr)) begin
                errors++;
                $display("FAIL rand_rom@%0d: got ena=%b rd=%b addr=%h exp ena=%b addr=%h", cyc, rom_ena, rom_read, rom_addr, exp_ena, exp_addr);
            end
            if (g >= 0) begin
                busy      = 1'b1;
                acc       = cyc;
                exp_id    = g;
                exp_addr  = paddr[g];
                exp_err   = (paddr[g] >= DEPTH);
                exp_data  = exp_err ? 8'h00 : mem[paddr[g][7:0]];
                model_ptr = (g + 1) % N;
                pend[g]   = 1'b0;
            end
            tick;
        end
        req_valid = '0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        rst = 1'b1; req_valid = '0; req_addr = '0; rsp_ready = 1'b0;
        test_reset;
        test_single;
        test_contention;
        test_backpressure;
        test_out_of_range;
        test_reset_midop;
`ifdef ROM_ARB_PARITY_EN
        test_parity;
`endif
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
